// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit control for a MIPS-style pipeline.
// The full 64-bit result is computed at issue and held in pending
// registers. A down-counter then models the unit's latency, and HI/LO
// update on the edge that ends the busy window.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        flush,
  input  logic        d_md_use,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_d, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d;
  logic [31:0]   pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;

  // Result datapath signals (one shared divider for signed and unsigned)
  logic          is_signed, neg_a, neg_b;
  logic [31:0]   abs_a, abs_b, div_den;
  logic [31:0]   quo_mag, rem_mag, quo, rem;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   res_hi, res_lo;
  logic          res_wr;

  // Compute the full result of the requested operation from the current operands
  always_comb begin
    // NOTE: every signal assigned in an always_comb block gets a default first, so no path leaves it unassigned and no latch is inferred.
    res_hi    = 32'd0;
    res_lo    = 32'd0;
    res_wr    = 1'b1;
    is_signed = ~op[0];
    neg_a     = is_signed & rs_val[31];
    neg_b     = is_signed & rt_val[31];
    abs_a     = neg_a ? -rs_val : rs_val;
    abs_b     = neg_b ? -rt_val : rt_val;
    // A zero divisor never commits; substitute 1 so the divider never sees 0.
    div_den   = (rt_val == 32'd0) ? 32'd1 : abs_b;
    quo_mag   = abs_a / div_den;
    rem_mag   = abs_a % div_den;
    // Quotient truncates toward zero; remainder takes the dividend's sign.
    // 0x80000000 / -1 falls out naturally: magnitude 2^31 negates to itself.
    quo       = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
    rem       = neg_a ? -rem_mag : rem_mag;
    // Low 64 bits of the sign-extended product equal the signed product.
    prod_s    = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u    = {32'd0, rs_val} * {32'd0, rt_val};
    unique case (op_t'(op))
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      default: begin
        res_hi = rem;
        res_lo = quo;
        res_wr = (rt_val != 32'd0);
      end
    endcase
  end

  // Next-state, counter, pending-result and HI/LO update logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi;
    lo_d      = lo;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          // Issue takes priority over mthi/mtlo in the same cycle.
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_wr_d = res_wr;
          if (op[1]) begin
            state_d = ST_DIV;
            cnt_d   = CW'(DIV_CYCLES);
          end else begin
            state_d = ST_MULT;
            cnt_d   = CW'(MULT_CYCLES);
          end
        end else if (!flush) begin
          if (mthi) hi_d = rs_val;
          if (mtlo) lo_d = rs_val;
        end
      end
      ST_MULT, ST_DIV: begin
        // Issued operations always commit: flush, start and mthi/mtlo are ignored here.
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and data registers; reset abandons any in-flight operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the pending result is ordinary flop storage, so it is reset along with HI/LO; nothing stale can commit after reset.
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi        <= hi_d;
      lo        <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Status outputs
  assign busy  = (state_q != ST_IDLE);
  assign stall = d_md_use & (busy | (start & ~flush));

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration in cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration in cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  E-stage mult/multu/div/divu issue request, one-cycle pulse.
REQ-006 op  input  2  operation: 0 mult, 1 multu, 2 div, 3 divu; sampled only when start=1.
REQ-007 rs_val  input  32  operand A (multiplicand or dividend).
REQ-008 rt_val  input  32  operand B (multiplier or divisor).
REQ-009 mthi  input  1  write rs_val to HI.
REQ-010 mtlo  input  1  write rs_val to LO.
REQ-011 flush  input  1  E-stage instruction cancelled by exception/interrupt this cycle.
REQ-012 d_md_use  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.
REQ-015 busy  output  1  operation in progress.
REQ-016 stall  output  1  freeze request to hazard unit.

Function
REQ-017 States: IDLE, MULT, DIV; state, counter, hi, lo, pending result are registers.
REQ-018 IDLE and start=1 and flush=0: latch full result into pending HI/LO, load counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3), enter MULT or DIV.
REQ-019 busy = 1 exactly when state is not IDLE, i.e. from the cycle after start for N cycles (N = loaded count).
REQ-020 In MULT/DIV, counter decrements each cycle; at counter=1 the next edge writes pending result to hi/lo and returns to IDLE; new hi/lo visible on the first cycle busy=0.
REQ-021 mult: signed 32x32 -> 64-bit product; hi = bits 63:32, lo = bits 31:0. multu: same, unsigned.
REQ-022 div: signed; lo = quotient truncated toward zero, hi = remainder with sign of dividend. divu: unsigned.
REQ-023 Divisor = 0: operation still runs DIV_CYCLES busy cycles; hi and lo keep previous values on completion.
REQ-024 Signed overflow case 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
REQ-025 start=1 with flush=1: ignored; no state change.
REQ-026 start=1 while busy: ignored; running operation unaffected (stall prevents it in normal flow).
REQ-027 flush while busy: no effect; an issued operation always commits.
REQ-028 mthi/mtlo in IDLE with flush=0: next edge writes rs_val to hi/lo respectively; both may assert together.
REQ-029 mthi/mtlo while busy, or with flush=1: ignored.
REQ-030 start and mthi/mtlo in the same cycle: start takes priority; mthi/mtlo ignored.
REQ-031 stall = d_md_use & (busy | (start & ~flush)), combinational.
REQ-032 Pending result computed from operands at start; rs_val/rt_val changes during busy have no effect.

Reset
REQ-033 reset=0 forces immediately, independent of clk: state IDLE, counter 0, hi=0, lo=0, pending=0, busy=0.
REQ-034 reset asserted mid-operation abandons it; hi/lo read 0 after release, pending result never written.
REQ-035 stall during reset equals d_md_use & start & ~flush (busy is 0).

Verification
REQ-036 mult rs=0xFFFFFFFF, rt=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-037 div rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu rs=7, rt=0 -> busy 10 cycles, hi/lo unchanged.
REQ-038 mthi rs=0x12345678 then mtlo rs=0x9ABCDEF0 in IDLE -> hi=0x12345678, lo=0x9ABCDEF0 next cycle; mthi issued during busy -> hi unchanged.
REQ-039 start with flush=1 -> busy stays 0, hi/lo unchanged, stall=0; start with d_md_use=1, flush=0 -> stall=1 that cycle and all 5 busy cycles, 0 after.
REQ-040 reset pulsed low at busy cycle 3 of a div -> busy=0, hi=lo=0 immediately; operation never commits after release.
REQ-041 back-to-back: second start on the cycle busy falls -> first result visible that cycle, second operation busy next cycle, commits correctly.
